// File: rtl/op_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : op_dispatch
//  Purpose  : Command front-end of the FP arithmetic datapath. Buffers
//             {opcode, A, B} commands in a small FIFO and issues them one at a
//             time, strictly in order, to the add / mul / sine units. It waits
//             for the selected unit's done before issuing the next command.
//  Ports    : clk, n_rst (sync, active low)
//             cmd_valid/cmd_op/cmd_a/cmd_b/cmd_ready - command push interface
//             op_a/op_b                - operands broadcast to all units
//             add/mul/sine_start       - one-cycle start pulses
//             add/mul/sine_done        - unit completion inputs
//             fifo_out                 - opcode in flight (3'b000 when none)
//             busy                     - operation in flight or FIFO non-empty
//             illegal_op               - pulse: illegal opcode dropped
//             timeout                  - pulse: watchdog abort
//  Options  : OP_DISPATCH_WATCHDOG_EN - enables the WAIT watchdog
//             (WD_CYCLES). When undefined, timeout is tied 0.
//  Revision : 1.0 - initial release
// ============================================================================
module op_dispatch #(
   parameter int DEPTH     = 4,
   parameter int WD_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        cmd_valid,
   input  logic [2:0]  cmd_op,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   output logic        cmd_ready,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   output logic        add_start,
   output logic        mul_start,
   output logic        sine_start,
   input  logic        add_done,
   input  logic        mul_done,
   input  logic        sine_done,
   output logic [2:0]  fifo_out,
   output logic        busy,
   output logic        illegal_op,
   output logic        timeout
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_SINE = 3'b100;

   // Elaboration-time sanity check of the configuration.
   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WD_CYCLES < 2) begin : g_bad_param
         $error("op_dispatch: DEPTH must be a power of two >= 2 and WD_CYCLES >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [2:0]    mem_op [DEPTH];
   logic [31:0]   mem_a  [DEPTH];
   logic [31:0]   mem_b  [DEPTH];

   logic [AW-1:0] wr_ptr, rd_ptr, head_ptr;
   logic [CW-1:0] count;

   logic full, legal, accept, push, pop;
   logic load_head, clear_out, sel_done, wd_fire;

   assign full      = (count == CW'(DEPTH));
   assign cmd_ready = !full;
   assign legal     = (cmd_op == OP_ADD) || (cmd_op == OP_MUL) || (cmd_op == OP_SINE);
   assign accept    = cmd_valid && cmd_ready;
   assign push      = accept && legal;

   // Only the unit matching the in-flight opcode may complete it.
   assign sel_done = ((fifo_out == OP_ADD)  && add_done) ||
                     ((fifo_out == OP_MUL)  && mul_done) ||
                     ((fifo_out == OP_SINE) && sine_done);

   assign add_start  = (state == ST_ISSUE) && (fifo_out == OP_ADD);
   assign mul_start  = (state == ST_ISSUE) && (fifo_out == OP_MUL);
   assign sine_start = (state == ST_ISSUE) && (fifo_out == OP_SINE);

   assign busy = (state != ST_IDLE) || (count != '0);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and datapath controls
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      load_head = 1'b0;
      clear_out = 1'b0;
      head_ptr  = rd_ptr;
      case (state)
         ST_IDLE: begin
            if (count != '0) begin
               state_nxt = ST_ISSUE;
               load_head = 1'b1;
            end
         end
         ST_ISSUE: begin
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (sel_done || wd_fire) begin
               pop = 1'b1;
               // Remaining entries (ignoring a same-edge push, whose data is
               // not yet readable) decide between chaining and idling.
               if (count != CW'(1)) begin
                  state_nxt = ST_ISSUE;
                  load_head = 1'b1;
                  head_ptr  = rd_ptr + 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
                  clear_out = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FIFO storage (contents need no reset; pointers/count define validity)
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         mem_op[wr_ptr] <= cmd_op;
         mem_a[wr_ptr]  <= cmd_a;
         mem_b[wr_ptr]  <= cmd_b;
      end
   end

   // ------------------------------------------------------------------
   // Pointers, count, in-flight registers, illegal pulse
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         op_a       <= '0;
         op_b       <= '0;
         fifo_out   <= '0;
         illegal_op <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (load_head) begin
            op_a     <= mem_a[head_ptr];
            op_b     <= mem_b[head_ptr];
            fifo_out <= mem_op[head_ptr];
         end else if (clear_out) begin
            fifo_out <= '0;
         end
         illegal_op <= accept && !legal;
      end
   end

   // ------------------------------------------------------------------
   // Optional WAIT watchdog
   // ------------------------------------------------------------------
`ifdef OP_DISPATCH_WATCHDOG_EN
   localparam int WDW = $clog2(WD_CYCLES) + 1;

   logic [WDW-1:0] wd_cnt;

   // A done arriving on the expiry edge wins: normal completion, no timeout.
   assign wd_fire = (state == ST_WAIT) && !sel_done &&
                    (wd_cnt == WDW'(WD_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         wd_cnt  <= '0;
         timeout <= 1'b0;
      end else begin
         timeout <= wd_fire;
         if (state == ST_ISSUE) begin
            wd_cnt <= '0;
         end else if (state == ST_WAIT) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
      end
   end
`else
   assign wd_fire = 1'b0;
   assign timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_op_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_op_dispatch
//  Purpose  : Directed self-checking bench for op_dispatch: reset state,
//             single add, full FIFO with in-order issue, illegal opcode,
//             foreign done filtering, reset mid-operation, watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_op_dispatch;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        cmd_valid;
   logic [2:0]  cmd_op;
   logic [31:0] cmd_a, cmd_b;
   logic        cmd_ready;
   logic [31:0] op_a, op_b;
   logic        add_start, mul_start, sine_start;
   logic        add_done, mul_done, sine_done;
   logic [2:0]  fifo_out;
   logic        busy, illegal_op, timeout;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   op_dispatch #(.DEPTH(4), .WD_CYCLES(8)) dut (
      .clk(clk), .n_rst(n_rst),
      .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .cmd_ready(cmd_ready), .op_a(op_a), .op_b(op_b),
      .add_start(add_start), .mul_start(mul_start), .sine_start(sine_start),
      .add_done(add_done), .mul_done(mul_done), .sine_done(sine_done),
      .fifo_out(fifo_out), .busy(busy), .illegal_op(illegal_op), .timeout(timeout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs settle 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
   endtask

   task automatic check_starts(input string tag, input logic [2:0] exp);
      check({tag, "_starts"}, {29'd0, sine_start, mul_start, add_start}, {29'd0, exp});
   endtask

   // expected values for the 4-deep burst
   logic [2:0]  burst_op [4];
   logic [31:0] burst_a  [4];

   initial begin
      n_rst = 1'b0; cmd_valid = 1'b0; cmd_op = 3'b0; cmd_a = '0; cmd_b = '0;
      add_done = 1'b0; mul_done = 1'b0; sine_done = 1'b0;
      burst_op[0] = 3'b010; burst_a[0] = 32'h1111_0001;
      burst_op[1] = 3'b100; burst_a[1] = 32'h2222_0002;
      burst_op[2] = 3'b001; burst_a[2] = 32'h3333_0003;
      burst_op[3] = 3'b010; burst_a[3] = 32'h4444_0004;

      // ---------------- reset state ----------------
      tick(); tick();
      check("rst_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_fifo_out", {29'd0, fifo_out}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_op_a", op_a, 32'd0);
      check("rst_op_b", op_b, 32'd0);
      check_starts("rst", 3'b000);
      check("rst_illegal", {31'd0, illegal_op}, 32'd0);
      check("rst_timeout", {31'd0, timeout}, 32'd0);
      n_rst = 1'b1;
      tick();

      // ---------------- single add ----------------
      drive_cmd(3'b001, 32'h3F80_0000, 32'h4000_0000);
      tick();                          // accept edge
      cmd_valid = 1'b0;
      check_starts("add_c1", 3'b000);
      check("add_c1_busy", {31'd0, busy}, 32'd1);
      tick();
      check_starts("add_c2", 3'b001);
      check("add_c2_fifo_out", {29'd0, fifo_out}, 32'd1);
      check("add_c2_op_a", op_a, 32'h3F80_0000);
      check("add_c2_op_b", op_b, 32'h4000_0000);
      tick();
      check_starts("add_wait", 3'b000);
      check("add_wait_fifo_out", {29'd0, fifo_out}, 32'd1);
      tick();
      add_done = 1'b1;
      tick();
      add_done = 1'b0;
      check("add_done_fifo_out", {29'd0, fifo_out}, 32'd0);
      check("add_done_busy", {31'd0, busy}, 32'd0);

      // ---------------- fill FIFO, in-order issue ----------------
      for (int i = 0; i < 4; i++) begin
         drive_cmd(burst_op[i], burst_a[i], ~burst_a[i]);
         tick();
      end
      check("full_ready", {31'd0, cmd_ready}, 32'd0);
      drive_cmd(3'b001, 32'hDEAD_BEEF, 32'h0);   // 5th: must be refused
      tick();
      cmd_valid = 1'b0;
      check("full_ready2", {31'd0, cmd_ready}, 32'd0);
      check("full_head_op", {29'd0, fifo_out}, 32'd2);
      check("full_head_a", op_a, burst_a[0]);
      check("full_head_b", op_b, ~burst_a[0]);
      for (int i = 0; i < 4; i++) begin
         case (burst_op[i])
            3'b001:  add_done  = 1'b1;
            3'b010:  mul_done  = 1'b1;
            default: sine_done = 1'b1;
         endcase
         tick();
         add_done = 1'b0; mul_done = 1'b0; sine_done = 1'b0;
         if (i < 3) begin
            check_starts($sformatf("burst%0d", i + 1), burst_op[i + 1]);
            check($sformatf("burst%0d_fifo_out", i + 1), {29'd0, fifo_out}, {29'd0, burst_op[i + 1]});
            check($sformatf("burst%0d_op_a", i + 1), op_a, burst_a[i + 1]);
            check($sformatf("burst%0d_ready", i + 1), {31'd0, cmd_ready}, 32'd1);
            tick();
            check_starts($sformatf("burst%0d_wait", i + 1), 3'b000);
         end else begin
            check("burst_end_fifo_out", {29'd0, fifo_out}, 32'd0);
            check("burst_end_busy", {31'd0, busy}, 32'd0);
         end
      end

      // ---------------- illegal opcode ----------------
      tick();
      drive_cmd(3'b011, 32'h1234_5678, 32'h0);
      tick();
      cmd_valid = 1'b0;
      check("illegal_pulse", {31'd0, illegal_op}, 32'd1);
      check("illegal_busy", {31'd0, busy}, 32'd0);
      tick();
      check("illegal_pulse_end", {31'd0, illegal_op}, 32'd0);
      check_starts("illegal", 3'b000);
      check("illegal_busy2", {31'd0, busy}, 32'd0);
      tick();
      check_starts("illegal2", 3'b000);

      // ---------------- foreign done ignored ----------------
      drive_cmd(3'b010, 32'h5555_AAAA, 32'h0);
      tick();
      cmd_valid = 1'b0;
      tick();
      check_starts("fd_issue", 3'b010);
      tick();
      add_done = 1'b1; sine_done = 1'b1;
      tick();
      add_done = 1'b0; sine_done = 1'b0;
      check("fd_fifo_out", {29'd0, fifo_out}, 32'd2);
      check("fd_busy", {31'd0, busy}, 32'd1);
      check_starts("fd_wait", 3'b000);
      mul_done = 1'b1;
      tick();
      mul_done = 1'b0;
      check("fd_pop_fifo_out", {29'd0, fifo_out}, 32'd0);
      check("fd_pop_busy", {31'd0, busy}, 32'd0);

      // ---------------- reset during WAIT with 2 queued ----------------
      drive_cmd(3'b010, 32'h0000_0010, 32'h0); tick();
      drive_cmd(3'b100, 32'h0000_0020, 32'h0); tick();
      drive_cmd(3'b001, 32'h0000_0030, 32'h0); tick();
      cmd_valid = 1'b0;
      tick();
      check("mr_pre_fifo_out", {29'd0, fifo_out}, 32'd2);
      n_rst = 1'b0;
      tick();
      n_rst = 1'b1;
      check("mr_fifo_out", {29'd0, fifo_out}, 32'd0);
      check("mr_busy", {31'd0, busy}, 32'd0);
      check("mr_ready", {31'd0, cmd_ready}, 32'd1);
      check("mr_op_a", op_a, 32'd0);
      mul_done = 1'b1;
      tick();
      mul_done = 1'b0;
      check("mr_done_fifo_out", {29'd0, fifo_out}, 32'd0);
      check("mr_done_busy", {31'd0, busy}, 32'd0);
      tick();
      check_starts("mr_after", 3'b000);

      // ---------------- watchdog / indefinite WAIT ----------------
      drive_cmd(3'b001, 32'h0000_0040, 32'h0);
      tick();                          // accept
      cmd_valid = 1'b0;
      tick();                          // ISSUE
      tick();                          // first WAIT cycle
`ifdef OP_DISPATCH_WATCHDOG_EN
      for (int i = 0; i < 7; i++) tick();
      check("wd_pre_timeout", {31'd0, timeout}, 32'd0);
      check("wd_pre_fifo_out", {29'd0, fifo_out}, 32'd1);
      tick();
      check("wd_timeout", {31'd0, timeout}, 32'd1);
      check("wd_fifo_out", {29'd0, fifo_out}, 32'd0);
      check("wd_busy", {31'd0, busy}, 32'd0);
      tick();
      check("wd_timeout_end", {31'd0, timeout}, 32'd0);
`else
      for (int i = 0; i < 20; i++) tick();
      check("nowd_timeout", {31'd0, timeout}, 32'd0);
      check("nowd_fifo_out", {29'd0, fifo_out}, 32'd1);
      check("nowd_busy", {31'd0, busy}, 32'd1);
      add_done = 1'b1;
      tick();
      add_done = 1'b0;
      check("nowd_fifo_out_end", {29'd0, fifo_out}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/op_dispatch.md
Name: op_dispatch

Overview:
- Command front-end of the FP arithmetic datapath. Buffers incoming {opcode, operand A, operand B} commands in a small FIFO.
- Issues one operation at a time to the add, mul or sine unit with a single-cycle start pulse.
- Holds the in-flight opcode on fifo_out, which the output decode stage uses to select the matching result, done and overflow.
- Waits for the selected unit's done before issuing the next command. Strictly in-order, one operation outstanding.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- WD_CYCLES, 1024, watchdog timeout in cycles (used only with WATCHDOG_EN).

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_op  in  3  opcode: 3'b001 add, 3'b010 mul, 3'b100 sine; all other codes illegal.
- cmd_a  in  32  IEEE-754 single operand A.
- cmd_b  in  32  IEEE-754 single operand B (ignored by sine).
- cmd_ready  out  1  FIFO can accept a command.
- op_a  out  32  operand A to all units.
- op_b  out  32  operand B to all units.
- add_start  out  1  one-cycle start to adder.
- mul_start  out  1  one-cycle start to multiplier.
- sine_start  out  1  one-cycle start to sine unit.
- add_done  in  1  adder complete.
- mul_done  in  1  multiplier complete.
- sine_done  in  1  sine complete.
- fifo_out  out  3  opcode of in-flight operation; 3'b000 when none.
- busy  out  1  operation in flight or FIFO non-empty.
- illegal_op  out  1  one-cycle pulse: illegal opcode dropped.
- timeout  out  1  one-cycle pulse: watchdog abort (WATCHDOG_EN only, else tied 0).

Behaviour:
- Reset (n_rst low at a rising edge):
  - FIFO emptied, pointers and count cleared, FSM to IDLE.
  - op_a/op_b = 0, all starts 0, fifo_out = 0, busy 0, illegal_op 0, timeout 0, watchdog counter 0.
  - Applies mid-operation too: the in-flight operation is abandoned and any later unit done is ignored.
- Push and accept rules:
  - cmd_ready = !full; there is no push-when-full bypass, even on a same-cycle pop.
  - A command is accepted on an edge with cmd_valid & cmd_ready.
  - A legal opcode is written at the write pointer and count increments.
  - An illegal opcode is not written; illegal_op is high the following cycle.
  - Pointers wrap modulo DEPTH. Count range is 0..DEPTH, so the count is clog2(DEPTH)+1 bits.
- FSM, registered states IDLE, ISSUE, WAIT:
  - IDLE: when count != 0, go to ISSUE and latch head entry into op_a/op_b/fifo_out.
  - ISSUE: for exactly one cycle, assert the start matching fifo_out; go to WAIT.
  - WAIT: hold op_a/op_b/fifo_out. The selected unit's done (e.g. mul_done when fifo_out = 3'b010) pops the head and clears fifo_out to 0. Go to ISSUE directly (latching the new head) if count after pop != 0, else IDLE.
  - Done from a non-selected unit, or any done outside WAIT, is ignored.
- Latency:
  - An accept edge into an empty, idle block gives IDLE->ISSUE on the next edge.
  - The start pulse is therefore high in the second cycle after the accepting edge.
  - Back-to-back: done in cycle k, next start in cycle k+1.
- Simultaneous push and pop in the same edge: count unchanged, both pointers advance.
- busy = (state != IDLE) | (count != 0).

Optional Feature:
- Macro: OP_DISPATCH_WATCHDOG_EN.
- Defined:
  - Counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches WD_CYCLES - 1 without the selected done, the head is popped and fifo_out cleared. timeout pulses for one cycle and the FSM proceeds as if done had arrived.
  - Done on the same edge as expiry counts as normal completion; no timeout.
- Undefined: no counter; timeout tied 0; WAIT lasts indefinitely.

Test Plan:
- Reset, then one add (op 3'b001, A=32'h3F800000, B=32'h40000000) -> add_start high 2 cycles after accept, op_a/op_b match, fifo_out=3'b001 until add_done, then 0, busy falls.
- Push 4 commands (mul, sine, add, mul) with no done -> cmd_ready low after 4th; 5th cmd_valid not accepted; each done issues next start one cycle later, in order.
- Illegal op 3'b011 -> illegal_op pulse, count unchanged, no start.
- In WAIT for mul, pulse add_done and sine_done -> ignored; mul_done -> pop.
- n_rst low during WAIT with 2 queued -> FIFO empty, fifo_out 0, later mul_done ignored.
- With OP_DISPATCH_WATCHDOG_EN, WD_CYCLES=8, no done -> timeout pulse after 8 WAIT cycles, head popped.
